vlb_ttw_fanout: RTL and testbench

- Parametrised successor to the fixed two-way ILB/DLB TTW split: one shared table-walker result stream is fanned out to NCH VLB request channels.
- Channel is selected by the top idx bits. Each channel gets a buffered ready/valid response queue, an outstanding-walk counter driving busy, and kill-driven flush with in-flight drop.
- Also merges per-channel kills into the walker's 3-bit kill vector, in AND or OR mode.
- Sits between the walker (ilb/dlb ttw_o, kill_i) and the per-channel VLB front ends.

---
 rtl/vlb_pkg.sv | 26 ++
 rtl/vlb_ttw_chq.sv | 128 ++++++++++++
 rtl/vlb_ttw_fanout.sv | 90 +++++++++
 tb/tb_vlb_ttw_fanout.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vlb_pkg.sv
// Shared types and constants for the VLB table-walker fan-out.
//   ttw_res_t   : one walker result {idx, vld, err, mpn, attr} at the default widths
//   ch_w()      : width of the channel-select field for a given channel count
//   KILL_FLUSH / KILL_ABORT : bit positions inside each channel's 2-bit kill
package vlb_pkg;

  localparam int VLB_LW = 5;
  localparam int VLB_MW = 52;
  localparam int VLB_AW = 8;

  localparam int KILL_FLUSH = 0;
  localparam int KILL_ABORT = 1;

  typedef struct packed {
    logic [VLB_LW-1:0] idx;
    logic              vld;
    logic              err;
    logic [VLB_MW-1:0] mpn;
    logic [VLB_AW-1:0] attr;
  } ttw_res_t;

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/vlb_ttw_chq.sv
// One VLB channel: response FIFO, outstanding-walk counter, in-flight drop
// counter and sticky protocol error.
//   clock, reset          : clock, async active-low reset
//   i_req                 : walk issued for this channel
//   i_acc                 : walker result for this channel accepted this cycle
//   i_kill                : flush request (kill bit0)
//   i_rdy                 : consumer ready
//   i_idx..i_attr         : result payload
//   o_valid, o_idx..o_attr: head-of-queue result
//   o_full, o_drop_nz     : feed the shared ready mux in the top
//   o_busy, o_err         : outstanding walks / sticky protocol error
module vlb_ttw_chq #(
  parameter int LW    = 5,
  parameter int MW    = 52,
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int MAXO  = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic          i_acc,
  input  logic          i_kill,
  input  logic          i_rdy,
  input  logic [LW-1:0] i_idx,
  input  logic          i_vld,
  input  logic          i_err,
  input  logic [MW-1:0] i_mpn,
  input  logic [AW-1:0] i_attr,
  output logic          o_valid,
  output logic [LW-1:0] o_idx,
  output logic          o_vld,
  output logic          o_rerr,
  output logic [MW-1:0] o_mpn,
  output logic [AW-1:0] o_attr,
  output logic          o_full,
  output logic          o_drop_nz,
  output logic          o_busy,
  output logic          o_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAXO + 1);

  typedef struct packed {
    logic [LW-1:0] idx;
    logic          vld;
    logic          err;
    logic [MW-1:0] mpn;
    logic [AW-1:0] attr;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_out, r_drop;
  logic          r_err;

  logic w_push, w_pop, w_empty, w_req_ovf, w_acc_unf;

  assign w_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_drop_nz = (r_drop != '0);
  assign o_valid   = ~w_empty & ~i_kill;
  // Results that belong to a killed batch are swallowed instead of queued.
  assign w_push    = i_acc & ~o_drop_nz & ~i_kill;
  assign w_pop     = o_valid & i_rdy;
  assign w_req_ovf = i_req & (r_out == OW'(MAXO));
  assign w_acc_unf = i_acc & (r_out == '0);

  assign o_idx  = r_mem[r_rp].idx;
  assign o_vld  = r_mem[r_rp].vld;
  assign o_rerr = r_mem[r_rp].err;
  assign o_mpn  = r_mem[r_rp].mpn;
  assign o_attr = r_mem[r_rp].attr;
  assign o_busy = (r_out != '0);
  assign o_err  = r_err;

  // NOTE: payload storage has no reset; o_valid masks stale entries, and
  // leaving it unreset lets it map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp] <= entry_t'{i_idx, i_vld, i_err, i_mpn, i_attr};
  end

  // NOTE: all state uses non-blocking assignments so every register sees the
  // pre-edge values of its peers, independent of block evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_kill) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_req && !i_acc && !w_req_ovf)      r_out <= r_out + OW'(1);
      else if (i_acc && !i_req && !w_acc_unf) r_out <= r_out - OW'(1);
      r_err <= r_err | w_req_ovf | w_acc_unf;
    end
  end

  // On kill, every walk still outstanding (less one accepted right now) will
  // come back later and must be dropped. A same-cycle req is not included.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_drop <= '0;
    end else if (i_kill) begin
      r_drop <= (i_acc && r_out != '0) ? r_out - OW'(1) : r_out;
    end else if (i_acc && o_drop_nz) begin
      r_drop <= r_drop - OW'(1);
    end
  end

endmodule

// File: rtl/vlb_ttw_fanout.sv
// Fans one table-walker result stream out to NCH VLB channels and merges the
// per-channel kills into the walker's 3-bit kill vector.
//   clock, reset             : clock, async active-low reset
//   req_valid_i              : per-channel walk-issued pulse
//   ttw_*_i / ttw_ready_o    : walker result stream, idx = {channel, local idx}
//   res_*_o / res_ready_i    : per-channel buffered results (flattened)
//   kill_i / kill_o          : per-channel {abort, flush} in, merged kill out
//   busy_o, err_o            : outstanding walks, sticky protocol error
module vlb_ttw_fanout
  import vlb_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int LW    = VLB_LW,
  parameter int MW    = VLB_MW,
  parameter int AW    = VLB_AW,
  parameter int DEPTH = 4,
  parameter int MAXO  = 8,
  parameter bit KAND  = 1'b1,
  localparam int CHW  = ch_w(NCH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid_i,
  input  logic              ttw_valid_i,
  output logic              ttw_ready_o,
  input  logic [LW+CHW-1:0] ttw_idx_i,
  input  logic              ttw_vld_i,
  input  logic              ttw_err_i,
  input  logic [MW-1:0]     ttw_mpn_i,
  input  logic [AW-1:0]     ttw_attr_i,
  output logic [NCH-1:0]    res_valid_o,
  input  logic [NCH-1:0]    res_ready_i,
  output logic [NCH*LW-1:0] res_idx_o,
  output logic [NCH-1:0]    res_vld_o,
  output logic [NCH-1:0]    res_err_o,
  output logic [NCH*MW-1:0] res_mpn_o,
  output logic [NCH*AW-1:0] res_attr_o,
  input  logic [NCH*2-1:0]  kill_i,
  output logic [2:0]        kill_o,
  output logic [NCH-1:0]    busy_o,
  output logic [NCH-1:0]    err_o
);

  logic [CHW-1:0] w_ch;
  logic [LW-1:0]  w_lidx;
  logic [NCH-1:0] w_kill0, w_kill1, w_full, w_drop_nz;
  logic           w_acc, w_abort;

  assign w_ch   = ttw_idx_i[LW +: CHW];
  assign w_lidx = ttw_idx_i[LW-1:0];

  // A result is always taken when its channel will discard it anyway.
  assign ttw_ready_o = w_drop_nz[w_ch] | ~w_full[w_ch] | w_kill0[w_ch];
  assign w_acc       = ttw_valid_i & ttw_ready_o;

  assign w_abort = KAND ? (&w_kill1) : (|w_kill1);
  assign kill_o  = {{2{w_abort}}, |w_kill0};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_kill0[c] = kill_i[2*c + KILL_FLUSH];
    assign w_kill1[c] = kill_i[2*c + KILL_ABORT];

    vlb_ttw_chq #(
      .LW(LW), .MW(MW), .AW(AW), .DEPTH(DEPTH), .MAXO(MAXO)
    ) u_chq (
      .clock     (clock),
      .reset     (reset),
      .i_req     (req_valid_i[c]),
      .i_acc     (w_acc & (w_ch == CHW'(c))),
      .i_kill    (w_kill0[c]),
      .i_rdy     (res_ready_i[c]),
      .i_idx     (w_lidx),
      .i_vld     (ttw_vld_i),
      .i_err     (ttw_err_i),
      .i_mpn     (ttw_mpn_i),
      .i_attr    (ttw_attr_i),
      .o_valid   (res_valid_o[c]),
      .o_idx     (res_idx_o[c*LW +: LW]),
      .o_vld     (res_vld_o[c]),
      .o_rerr    (res_err_o[c]),
      .o_mpn     (res_mpn_o[c*MW +: MW]),
      .o_attr    (res_attr_o[c*AW +: AW]),
      .o_full    (w_full[c]),
      .o_drop_nz (w_drop_nz[c]),
      .o_busy    (busy_o[c]),
      .o_err     (err_o[c])
    );
  end

endmodule

// File: tb/tb_vlb_ttw_fanout.sv
// Directed bench for vlb_ttw_fanout (NCH=2, DEPTH=4, MAXO=8). A second
// instance with KAND=0 shares the stimulus to cover OR-mode kill merging.
module tb_vlb_ttw_fanout;

  localparam int LW = 5;
  localparam int MW = 52;
  localparam int AW = 8;

  logic          clock, reset;
  logic [1:0]    req_valid_i;
  logic          ttw_valid_i, ttw_ready_o, ttw_ready_or;
  logic [5:0]    ttw_idx_i;
  logic          ttw_vld_i, ttw_err_i;
  logic [MW-1:0] ttw_mpn_i;
  logic [AW-1:0] ttw_attr_i;
  logic [1:0]    res_valid_o, res_ready_i, res_vld_o, res_err_o;
  logic [2*LW-1:0] res_idx_o;
  logic [2*MW-1:0] res_mpn_o;
  logic [2*AW-1:0] res_attr_o;
  logic [3:0]    kill_i;
  logic [2:0]    kill_o, kill_o_or;
  logic [1:0]    busy_o, err_o;

  logic [1:0]      or_res_valid, or_vld, or_err, or_busy, or_perr;
  logic [2*LW-1:0] or_idx;
  logic [2*MW-1:0] or_mpn;
  logic [2*AW-1:0] or_attr;

  int n_checks = 0;
  int n_fail   = 0;

  vlb_ttw_fanout #(.NCH(2), .DEPTH(4), .MAXO(8), .KAND(1'b1)) u_dut (
    .clock(clock), .reset(reset), .req_valid_i(req_valid_i),
    .ttw_valid_i(ttw_valid_i), .ttw_ready_o(ttw_ready_o), .ttw_idx_i(ttw_idx_i),
    .ttw_vld_i(ttw_vld_i), .ttw_err_i(ttw_err_i), .ttw_mpn_i(ttw_mpn_i),
    .ttw_attr_i(ttw_attr_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_idx_o(res_idx_o), .res_vld_o(res_vld_o), .res_err_o(res_err_o),
    .res_mpn_o(res_mpn_o), .res_attr_o(res_attr_o), .kill_i(kill_i),
    .kill_o(kill_o), .busy_o(busy_o), .err_o(err_o)
  );

  vlb_ttw_fanout #(.NCH(2), .DEPTH(4), .MAXO(8), .KAND(1'b0)) u_dut_or (
    .clock(clock), .reset(reset), .req_valid_i(req_valid_i),
    .ttw_valid_i(ttw_valid_i), .ttw_ready_o(ttw_ready_or), .ttw_idx_i(ttw_idx_i),
    .ttw_vld_i(ttw_vld_i), .ttw_err_i(ttw_err_i), .ttw_mpn_i(ttw_mpn_i),
    .ttw_attr_i(ttw_attr_i), .res_valid_o(or_res_valid), .res_ready_i(res_ready_i),
    .res_idx_o(or_idx), .res_vld_o(or_vld), .res_err_o(or_err),
    .res_mpn_o(or_mpn), .res_attr_o(or_attr), .kill_i(kill_i),
    .kill_o(kill_o_or), .busy_o(or_busy), .err_o(or_perr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Returns 1 ns after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [5:0] idx, input logic [MW-1:0] mpn);
    ttw_valid_i = 1'b1;
    ttw_idx_i   = idx;
    ttw_vld_i   = 1'b1;
    ttw_err_i   = 1'b0;
    ttw_mpn_i   = mpn;
    ttw_attr_i  = 8'h5a;
  endtask

  task automatic reqs(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      req_valid_i = 2'b00;
      req_valid_i[ch] = 1'b1;
      tick();
    end
    req_valid_i = 2'b00;
  endtask

  initial begin
    int  got_n;
    bit  sent5;
    bit  acc5;

    reset = 1'b0;  req_valid_i = '0;  ttw_valid_i = 1'b0;  ttw_idx_i = '0;
    ttw_vld_i = 1'b0;  ttw_err_i = 1'b0;  ttw_mpn_i = '0;  ttw_attr_i = '0;
    res_ready_i = '0;  kill_i = '0;
    tick();
    tick();
    check("rst_res_valid", 64'(res_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    reset = 1'b1;
    tick();
    check("rst_ready", 64'(ttw_ready_o), 64'd1);

    // ---- single walk on channel 1
    res_ready_i = 2'b11;
    reqs(1, 1);
    check("t1_busy_after_req", 64'(busy_o), 64'b10);
    send(6'h23, 52'h12345);
    #1;
    check("t1_ready", 64'(ttw_ready_o), 64'd1);
    tick();
    ttw_valid_i = 1'b0;
    check("t1_res_valid", 64'(res_valid_o), 64'b10);
    check("t1_res_idx", 64'(res_idx_o[LW +: LW]), 64'd3);
    check("t1_res_mpn", 64'(res_mpn_o[MW +: MW]), 64'h12345);
    check("t1_res_attr", 64'(res_attr_o[AW +: AW]), 64'h5a);
    check("t1_res_vld", 64'(res_vld_o[1]), 64'd1);
    check("t1_busy_done", 64'(busy_o), 64'd0);
    tick();
    check("t1_popped", 64'(res_valid_o), 64'd0);

    // ---- backpressure on channel 0
    res_ready_i = 2'b10;
    reqs(0, 5);
    for (int i = 0; i < 4; i++) begin
      send(6'(i + 1), 52'(100 + i));
      #1;
      check("t2_ready_fill", 64'(ttw_ready_o), 64'd1);
      tick();
    end
    send(6'd5, 52'd104);
    #1;
    check("t2_ready_full", 64'(ttw_ready_o), 64'd0);
    tick();
    check("t2_ready_full_hold", 64'(ttw_ready_o), 64'd0);
    res_ready_i = 2'b11;
    got_n = 0;
    sent5 = 1'b0;
    for (int cyc = 0; cyc < 20 && got_n < 5; cyc++) begin
      #1;
      if (res_valid_o[0]) begin
        check("t2_drain_idx", 64'(res_idx_o[0 +: LW]), 64'(got_n + 1));
        check("t2_drain_mpn", 64'(res_mpn_o[0 +: MW]), 64'(100 + got_n));
        got_n++;
      end
      acc5 = ttw_valid_i & ttw_ready_o;
      tick();
      if (acc5) begin
        ttw_valid_i = 1'b0;
        sent5 = 1'b1;
      end
    end
    ttw_valid_i = 1'b0;
    check("t2_fifth_accepted", 64'(sent5), 64'd1);
    check("t2_drained_count", 64'(got_n), 64'd5);
    check("t2_empty", 64'(res_valid_o[0]), 64'd0);
    check("t2_busy_done", 64'(busy_o[0]), 64'd0);

    // ---- kill with walks in flight on channel 0
    res_ready_i = 2'b10;
    reqs(0, 3);
    send(6'h07, 52'habc);
    tick();
    ttw_valid_i = 1'b0;
    #1;
    check("t3_queued", 64'(res_valid_o[0]), 64'd1);
    check("t3_queued_idx", 64'(res_idx_o[0 +: LW]), 64'd7);
    kill_i = 4'b0001;
    #1;
    check("t3_valid_masked", 64'(res_valid_o[0]), 64'd0);
    check("t3_kill_o", 64'(kill_o), 64'b001);
    tick();
    kill_i = 4'b0000;
    #1;
    check("t3_flushed", 64'(res_valid_o[0]), 64'd0);
    check("t3_busy_inflight", 64'(busy_o[0]), 64'd1);
    for (int i = 0; i < 2; i++) begin
      send(6'h09, 52'hdead);
      #1;
      check("t3_ready_drop", 64'(ttw_ready_o), 64'd1);
      tick();
      ttw_valid_i = 1'b0;
      #1;
      check("t3_swallowed", 64'(res_valid_o[0]), 64'd0);
    end
    check("t3_busy_done", 64'(busy_o[0]), 64'd0);
    check("t3_no_err", 64'(err_o), 64'd0);

    // ---- kill merge (no clock edge while kills are applied)
    kill_i = 4'b1000;
    #1;
    check("t4_and_mode", 64'(kill_o), 64'b000);
    check("t4_or_mode", 64'(kill_o_or), 64'b110);
    kill_i = 4'b0001;
    #1;
    check("t4_flush_bit", 64'(kill_o), 64'b001);
    kill_i = 4'b1010;
    #1;
    check("t4_and_all", 64'(kill_o), 64'b110);
    kill_i = 4'b0000;
    tick();

    // ---- protocol errors
    res_ready_i = 2'b11;
    send(6'h21, 52'h1);
    tick();
    ttw_valid_i = 1'b0;
    check("t5_unexpected_result", 64'(err_o), 64'b10);
    tick();
    check("t5_err_sticky", 64'(err_o), 64'b10);
    reqs(0, 9);
    check("t5_overflow_err", 64'(err_o), 64'b11);
    check("t5_busy_sat", 64'(busy_o[0]), 64'd1);

    // ---- async reset mid-drain
    res_ready_i = 2'b00;
    for (int i = 0; i < 2; i++) begin
      send(6'(i + 2), 52'(200 + i));
      tick();
    end
    ttw_valid_i = 1'b0;
    check("t6_pending", 64'(res_valid_o[0]), 64'd1);
    res_ready_i = 2'b01;
    #1;
    reset = 1'b0;
    #1;
    check("t6_async_valid", 64'(res_valid_o), 64'd0);
    check("t6_async_busy", 64'(busy_o), 64'd0);
    check("t6_async_err", 64'(err_o), 64'd0);
    tick();
    reset = 1'b1;
    ttw_idx_i = 6'h01;
    #1;
    check("t6_ready_after", 64'(ttw_ready_o), 64'd1);
    check("t6_valid_after", 64'(res_valid_o), 64'd0);
    send(6'h01, 52'h5);
    tick();
    ttw_valid_i = 1'b0;
    check("t6_late_result_err", 64'(err_o), 64'b01);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
